// File: rtl/qstate_measure.sv
// Samples one measurement outcome from a 2**N amplitude vector.
// Optional QSTATE_COLLAPSE_EN adds the post-measurement collapsed state output.
package qstate_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } complex_num_t;

endpackage

module qstate_measure
  import qstate_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  complex_num_t [2**N-1:0]  state,
  input  logic [11:0]              rnd,
  output logic                     busy,
  output logic                     done,
  output logic [N-1:0]             outcome,
  output logic                     norm_err
`ifdef QSTATE_COLLAPSE_EN
  ,
  output complex_num_t [2**N-1:0]  collapsed
`endif
);

  localparam int L  = 2**N;
  localparam int CW = 16 + N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } fsm_t;

  fsm_t fsm;
  fsm_t fsm_nxt;

  complex_num_t [L-1:0] cap_state;
  logic [11:0]          cap_rnd;
  logic [N-1:0]         k;
  logic [CW-1:0]        cum;
  logic [N-1:0]         res_idx;
  logic                 res_err;

  complex_num_t  amp;
  logic [6:0]    mag_a;
  logic [6:0]    mag_b;
  logic [14:0]   sq_a;
  logic [14:0]   sq_b;
  logic [14:0]   p_k;
  logic [CW-1:0] cum_next;
  logic          hit;
  logic          last;
  logic          load;

  // Sign bit is dropped, so 0x80 counts as zero probability.
  always_comb begin
    amp      = cap_state[k];
    mag_a    = amp.a[6:0];
    mag_b    = amp.b[6:0];
    sq_a     = {8'd0, mag_a} * {8'd0, mag_a};
    sq_b     = {8'd0, mag_b} * {8'd0, mag_b};
    p_k      = sq_a + sq_b;
    cum_next = cum + CW'(p_k);
    hit      = cum_next > CW'(cap_rnd);
    last     = (k == N'(L - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= S_IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    busy    = 1'b0;
    load    = 1'b0;
    unique case (fsm)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          fsm_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (hit || last) begin
          fsm_nxt = S_DONE;
        end
      end
      S_DONE: begin
        fsm_nxt = S_IDLE;
      end
      default: begin
        fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_state <= '0;
      cap_rnd   <= '0;
      k         <= '0;
      cum       <= '0;
      res_idx   <= '0;
      res_err   <= 1'b0;
    end else if (load) begin
      cap_state <= state;
      cap_rnd   <= rnd;
      k         <= '0;
      cum       <= '0;
    end else if (fsm == S_SCAN) begin
      if (hit) begin
        res_idx <= k;
        res_err <= 1'b0;
      end else if (last) begin
        res_idx <= k;
        res_err <= 1'b1;
      end else begin
        cum <= cum_next;
        k   <= k + N'(1);
      end
    end
  end

  // Visible results only change together with the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      outcome  <= '0;
      norm_err <= 1'b0;
    end else begin
      done <= (fsm == S_DONE);
      if (fsm == S_DONE) begin
        outcome  <= res_idx;
        norm_err <= res_err;
      end
    end
  end

`ifdef QSTATE_COLLAPSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collapsed <= '0;
    end else if (fsm == S_DONE) begin
      collapsed <= '0;
      if (!res_err) begin
        collapsed[res_idx].a <= 8'h40;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qstate_measure.sv
// Randomized and directed bench for qstate_measure (N=2).
// Collapsed-state checks compile in only with QSTATE_COLLAPSE_EN.
module tb_qstate_measure;
  import qstate_pkg::*;

  localparam int N = 2;
  localparam int L = 4;

  typedef complex_num_t [L-1:0] vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  vec_t        state;
  logic [11:0] rnd;
  logic        busy;
  logic        done;
  logic [N-1:0] outcome;
  logic        norm_err;
`ifdef QSTATE_COLLAPSE_EN
  vec_t        collapsed;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  qstate_measure #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .state    (state),
    .rnd      (rnd),
    .busy     (busy),
    .done     (done),
    .outcome  (outcome),
    .norm_err (norm_err)
`ifdef QSTATE_COLLAPSE_EN
    ,
    .collapsed(collapsed)
`endif
  );

  // Walk the basis states, summing squared magnitudes until rnd is exceeded.
  task automatic model(input vec_t s, input int r,
                       output int oc, output bit err);
    int cum;
    bit found;
    cum = 0;
    found = 0;
    oc = L - 1;
    err = 1;
    for (int i = 0; i < L; i++) begin
      int ma;
      int mb;
      ma = int'(s[i].a & 8'h7f);
      mb = int'(s[i].b & 8'h7f);
      cum += ma * ma + mb * mb;
      if (!found && cum > r) begin
        found = 1;
        oc = i;
        err = 0;
      end
    end
  endtask

  function automatic vec_t model_collapse(input int oc, input bit err);
    vec_t v;
    v = '0;
    if (!err) v[oc].a = 8'h40;
    return v;
  endfunction

  function automatic vec_t fill(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    for (int i = 0; i < L; i++) begin
      v[i].a = a;
      v[i].b = b;
    end
    return v;
  endfunction

  task automatic run_meas(input vec_t s, input logic [11:0] r,
                          output int lat, output int bcnt);
    @(posedge clk); #1;
    state = s;
    rnd = r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < L; i++) begin
      state[i].a = 8'($urandom);
      state[i].b = 8'($urandom);
    end
    rnd = 12'($urandom);
    lat = -1;
    bcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    state = '0;
    rnd = '0;
    #12;
    checks++;
    if ({busy, done, outcome, norm_err} !== '0)
      $display("FAIL reset_outputs got=%b want=0",
               {busy, done, outcome, norm_err});
    else passed++;
`ifdef QSTATE_COLLAPSE_EN
    checks++;
    if (collapsed !== '0)
      $display("FAIL reset_collapsed got=%h want=0", collapsed);
    else passed++;
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_run(input string tag, input vec_t s,
                           input logic [11:0] r);
    int oc, lat, bcnt;
    bit err;
    model(s, int'(r), oc, err);
    run_meas(s, r, lat, bcnt);
    checks++;
    if (lat !== oc + 2)
      $display("FAIL %s latency got=%0d want=%0d", tag, lat, oc + 2);
    else passed++;
    checks++;
    if (outcome !== N'(oc))
      $display("FAIL %s outcome got=%0d want=%0d", tag, outcome, oc);
    else passed++;
    checks++;
    if (norm_err !== err)
      $display("FAIL %s norm_err got=%b want=%b", tag, norm_err, err);
    else passed++;
    checks++;
    if (bcnt !== oc + 1)
      $display("FAIL %s busy_cycles got=%0d want=%0d", tag, bcnt, oc + 1);
    else passed++;
`ifdef QSTATE_COLLAPSE_EN
    checks++;
    if (collapsed !== model_collapse(oc, err))
      $display("FAIL %s collapsed got=%h want=%h", tag, collapsed,
               model_collapse(oc, err));
    else passed++;
`endif
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0)
      $display("FAIL %s done_width got=%b want=0", tag, done);
    else passed++;
  endtask

  task automatic test_directed();
    vec_t v;
    check_run("all_half_r0", fill(8'h20, 8'h00), 12'd0);
    check_run("all_half_r2500", fill(8'h20, 8'h00), 12'd2500);
    v = '0;
    v[3].a = 8'hc0;
    check_run("neg_one_last", v, 12'd4095);
    check_run("neg_zero_all", fill(8'h80, 8'h80), 12'd0);
    v = '0;
    v[1].b = 8'h40;
    check_run("imag_one_idx1", v, 12'd100);
  endtask

  task automatic test_random();
    vec_t v;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < L; i++) begin
        logic [6:0] ma;
        logic [6:0] mb;
        ma = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 40));
        mb = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 40));
        v[i].a = {1'($urandom), ma};
        v[i].b = {1'($urandom), mb};
      end
      check_run($sformatf("rand%0d", it), v, 12'($urandom));
    end
  endtask

  task automatic test_reset_mid_scan();
    int dcnt, lat, bcnt;
    @(posedge clk); #1;
    state = fill(8'h20, 8'h00);
    rnd = 12'd2500;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1)
      $display("FAIL midscan_busy got=%b want=1", busy);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, outcome, norm_err} !== '0)
      $display("FAIL midscan_reset got=%b want=0",
               {busy, done, outcome, norm_err});
    else passed++;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt !== 0)
      $display("FAIL midscan_no_done got=%0d want=0", dcnt);
    else passed++;
    run_meas(fill(8'h20, 8'h00), 12'd2500, lat, bcnt);
    checks++;
    if (lat !== 4 || outcome !== 2'd2)
      $display("FAIL midscan_recover got=%0d/%0d want=4/2", lat, outcome);
    else passed++;
  endtask

  task automatic test_back_to_back();
    vec_t v;
    int lat, bcnt, oc_a, oc_b;
    bit err_a, err_b;
    model(fill(8'h20, 8'h00), 2500, oc_a, err_a);
    v = '0;
    v[3].a = 8'h40;
    model(v, 0, oc_b, err_b);
    run_meas(fill(8'h20, 8'h00), 12'd2500, lat, bcnt);
    checks++;
    if (lat !== oc_a + 2 || outcome !== N'(oc_a))
      $display("FAIL b2b_first got=%0d/%0d want=%0d/%0d",
               lat, outcome, oc_a + 2, oc_a);
    else passed++;
    state = v;
    rnd = 12'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < oc_b + 2; n++) begin
      checks++;
      if (outcome !== N'(oc_a) || done !== 1'b0)
        $display("FAIL b2b_hold n=%0d got=%0d/%b want=%0d/0",
                 n, outcome, done, oc_a);
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || outcome !== N'(oc_b) || norm_err !== err_b)
      $display("FAIL b2b_second got=%b/%0d/%b want=1/%0d/%b",
               done, outcome, norm_err, oc_b, err_b);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_scan();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
